hazard_tracker: RTL and testbench
=================================

# hazard_tracker

Pipeline bookkeeping block that is the producer side of the hazard unit's interface in the 5-stage pipelined core. Carries register addresses and write-type control bits from Decode through Execute, Memory and Writeback. Produces the register-match, write-enable and PC-write-pending signals that the hazard unit consumes, and obeys the stall/flush signals it returns. Also keeps saturating counters of stall and flush cycles for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- RA1D  in  4  Decode source register 1
- RA2D  in  4  Decode source register 2
- WA3D  in  4  Decode destination register
- RegWriteD  in  1  Decode instr writes register file
- MemtoRegD  in  1  Decode instr is a load
- PCSrcD  in  1  Decode instr writes PC
- CondExE  in  1  Execute-stage condition passed
- FlushE  in  1  from hazard unit; bubble Execute register
- StallD  in  1  from hazard unit; counted only (Decode register lives elsewhere)
- Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E  out  1 each  address matches
- RegWriteM, RegWriteW, MemtoRegE, PCSrcW  out  1 each  pipelined control
- PCWrPendingF  out  1  PC write in flight in D, E or M
- StallCnt  out  CNT_W  cycles with StallD=1
- FlushCnt  out  CNT_W  cycles with FlushE=1

## Operation
- E register (RA1E, RA2E, WA3E, RegWriteE, MemtoRegE, PCSrcE) loads the D inputs every clock.
- FlushE=1 at the edge loads all E fields with 0 (bubble).
- M register loads every clock:
  - WA3M ← WA3E
  - RegWriteM ← RegWriteE & CondExE
  - PCSrcM ← PCSrcE & CondExE
- W register loads every clock: WA3W ← WA3M, RegWriteW ← RegWriteM, PCSrcW ← PCSrcM.
- M and W have no stall and no flush.
- Match outputs, all 4-bit equality:
  - Match_1E_M = (RA1E==WA3M)
  - Match_1E_W = (RA1E==WA3W)
  - Match_2E_M = (RA2E==WA3M)
  - Match_2E_W = (RA2E==WA3W)
  - Match_12D_E = (RA1D==WA3E) | (RA2D==WA3E)
- Matches are raw: they are not qualified by any write enable. The hazard unit qualifies them with RegWriteM/RegWriteW/MemtoRegE. A bubble (WA3=0) may match R0; this is harmless because its enables are 0.
- PCWrPendingF = PCSrcD | PCSrcE | PCSrcM.
- Counters:
  - StallCnt += 1 on each edge with StallD=1; FlushCnt += 1 on each edge with FlushE=1.
  - Both saturate at 2^CNT_W−1; they never wrap.
  - Independent; both may increment in the same cycle.

## Timing
- Reset (reset=0) asynchronously clears every E/M/W register and both counters.
- Output values during reset:
  - RegWriteM, RegWriteW, MemtoRegE, PCSrcW, StallCnt, FlushCnt all 0.
  - Match_1E_M/_1E_W/_2E_M/_2E_W read 1, since all stored addresses are 0.
  - Match_12D_E = (RA1D==0)|(RA2D==0).
  - PCWrPendingF = PCSrcD.
- Deassertion takes effect at the next rising edge. Reset asserted mid-operation discards all in-flight state immediately.
- Latency: D inputs appear in E 1 cycle later, M 2 cycles, W 3 cycles.
- Match_12D_E and PCWrPendingF are combinational in the D inputs (same-cycle path to the hazard unit). All other outputs come from registered state only.
- FlushE and CondExE are sampled at the same edge. A flush bubbles E while the old E contents still advance to M, qualified by CondExE.
- A load-use stall (StallD=1, FlushE=1) repeats the same D inputs next cycle; E holds a bubble for exactly that one cycle.

## Test plan
- Reset: hold reset=0 with random inputs.
  - Required: RegWriteM=RegWriteW=MemtoRegE=PCSrcW=0, counters 0, Match_1E_M=1.
  - Release reset, then drive RegWriteD=1, WA3D=5, CondExE=1: RegWriteW=1 and WA3W=5 (Match with RA=5) exactly 3 edges later.
- Forwarding: issue WA3D=3/RegWriteD=1, then RA1D=3, then RA2D=3.
  - Required: Match_1E_M=1 in the cycle the reader is in E with the writer in M.
  - Required: Match_2E_W=1 for the second reader against the same writer in W.
- Condition fail: RegWriteD=1, PCSrcD=1, CondExE=0 while in E.
  - Required: RegWriteM=0 next cycle; PCSrcW stays 0.
  - Required: PCWrPendingF=1 for exactly the 2 cycles the instr is in D and E.
- Load-use: load WA3D=7/MemtoRegD=1 in E while RA1D=7 in D.
  - Required: Match_12D_E=1 and MemtoRegE=1.
  - Drive FlushE=1, StallD=1 for one edge. Required: E all zeros next cycle, StallCnt=1, FlushCnt=1.
- Branch: PCSrcD=1 with CondExE=1.
  - Required: PCWrPendingF=1 for 3 cycles, then PCSrcW=1 for 1 cycle.
- Saturation: CNT_W=2, hold StallD=1 for 6 edges.
  - Required: StallCnt=3 after edge 3 and stays 3; FlushCnt=0.

Source files
------------

// File: rtl/hazard_tracker.sv
// ============================================================================
// hazard_tracker : carries register addresses and write controls D->E->M->W,
//                  producing address matches for the hazard unit. Rev 1.0
// ============================================================================
`default_nettype none

module hazard_tracker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       WA3D,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             PCSrcD,
  input  logic             CondExE,
  input  logic             FlushE,
  input  logic             StallD,
  output logic             Match_1E_M,
  output logic             Match_1E_W,
  output logic             Match_2E_M,
  output logic             Match_2E_W,
  output logic             Match_12D_E,
  output logic             RegWriteM,
  output logic             RegWriteW,
  output logic             MemtoRegE,
  output logic             PCSrcW,
  output logic             PCWrPendingF,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  logic [3:0]       r_ra1_e;
  logic [3:0]       r_ra2_e;
  logic [3:0]       r_wa3_e;
  logic             r_regwrite_e;
  logic             r_memtoreg_e;
  logic             r_pcsrc_e;

  logic [3:0]       r_wa3_m;
  logic             r_regwrite_m;
  logic             r_pcsrc_m;

  logic [3:0]       r_wa3_w;
  logic             r_regwrite_w;
  logic             r_pcsrc_w;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ra1_e      <= 4'd0;
      r_ra2_e      <= 4'd0;
      r_wa3_e      <= 4'd0;
      r_regwrite_e <= 1'b0;
      r_memtoreg_e <= 1'b0;
      r_pcsrc_e    <= 1'b0;
    end else if (FlushE) begin
      r_ra1_e      <= 4'd0;
      r_ra2_e      <= 4'd0;
      r_wa3_e      <= 4'd0;
      r_regwrite_e <= 1'b0;
      r_memtoreg_e <= 1'b0;
      r_pcsrc_e    <= 1'b0;
    end else begin
      r_ra1_e      <= RA1D;
      r_ra2_e      <= RA2D;
      r_wa3_e      <= WA3D;
      r_regwrite_e <= RegWriteD;
      r_memtoreg_e <= MemtoRegD;
      r_pcsrc_e    <= PCSrcD;
    end
  end

  // Execute-stage condition result squashes the write controls on their way to M.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wa3_m      <= 4'd0;
      r_regwrite_m <= 1'b0;
      r_pcsrc_m    <= 1'b0;
      r_wa3_w      <= 4'd0;
      r_regwrite_w <= 1'b0;
      r_pcsrc_w    <= 1'b0;
    end else begin
      r_wa3_m      <= r_wa3_e;
      r_regwrite_m <= r_regwrite_e & CondExE;
      r_pcsrc_m    <= r_pcsrc_e & CondExE;
      r_wa3_w      <= r_wa3_m;
      r_regwrite_w <= r_regwrite_m;
      r_pcsrc_w    <= r_pcsrc_m;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallD && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (FlushE && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  // Raw address compares; the hazard unit qualifies them with the write enables.
  assign Match_1E_M   = (r_ra1_e == r_wa3_m);
  assign Match_1E_W   = (r_ra1_e == r_wa3_w);
  assign Match_2E_M   = (r_ra2_e == r_wa3_m);
  assign Match_2E_W   = (r_ra2_e == r_wa3_w);
  assign Match_12D_E  = (RA1D == r_wa3_e) | (RA2D == r_wa3_e);

  assign RegWriteM    = r_regwrite_m;
  assign RegWriteW    = r_regwrite_w;
  assign MemtoRegE    = r_memtoreg_e;
  assign PCSrcW       = r_pcsrc_w;
  assign PCWrPendingF = PCSrcD | r_pcsrc_e | r_pcsrc_m;

  assign StallCnt     = r_stall_cnt;
  assign FlushCnt     = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_tracker.sv
// ============================================================================
// tb_hazard_tracker : scoreboard bench for hazard_tracker (16-bit and 2-bit
//                     counter instances). Rev 1.0
// ============================================================================
`default_nettype none

module tb_hazard_tracker;

  logic        clk;
  logic        reset;
  logic [3:0]  RA1D, RA2D, WA3D;
  logic        RegWriteD, MemtoRegD, PCSrcD, CondExE, FlushE, StallD;

  logic        Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
  logic        RegWriteM, RegWriteW, MemtoRegE, PCSrcW, PCWrPendingF;
  logic [15:0] StallCnt, FlushCnt;

  logic        s_Match_1E_M, s_Match_1E_W, s_Match_2E_M, s_Match_2E_W, s_Match_12D_E;
  logic        s_RegWriteM, s_RegWriteW, s_MemtoRegE, s_PCSrcW, s_PCWrPendingF;
  logic [1:0]  s_StallCnt, s_FlushCnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic rw;
    logic pc;
  } sb_t;

  sb_t  sb_q[$];
  int   cnt_q[$];

  hazard_tracker #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
    .CondExE(CondExE), .FlushE(FlushE), .StallD(StallD),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
    .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W), .Match_12D_E(Match_12D_E),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcW(PCSrcW), .PCWrPendingF(PCWrPendingF),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  hazard_tracker #(.CNT_W(2)) dut_s (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
    .CondExE(CondExE), .FlushE(FlushE), .StallD(StallD),
    .Match_1E_M(s_Match_1E_M), .Match_1E_W(s_Match_1E_W),
    .Match_2E_M(s_Match_2E_M), .Match_2E_W(s_Match_2E_W), .Match_12D_E(s_Match_12D_E),
    .RegWriteM(s_RegWriteM), .RegWriteW(s_RegWriteW), .MemtoRegE(s_MemtoRegE),
    .PCSrcW(s_PCSrcW), .PCWrPendingF(s_PCWrPendingF),
    .StallCnt(s_StallCnt), .FlushCnt(s_FlushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one Decode slot. cond qualifies the instruction currently in E,
  // flush bubbles E at the coming edge; the expected W-stage controls of both
  // affected slots are recorded in the scoreboard.
  task automatic issue(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
                       input logic rw, input logic mr, input logic pc,
                       input logic cond, input logic flush, input logic stall);
    sb_t t;
    RA1D = ra1; RA2D = ra2; WA3D = wa3;
    RegWriteD = rw; MemtoRegD = mr; PCSrcD = pc;
    CondExE = cond; FlushE = flush; StallD = stall;
    if (sb_q.size() > 0) begin
      t = sb_q.pop_back();
      t.rw = t.rw & cond;
      t.pc = t.pc & cond;
      sb_q.push_back(t);
    end
    t.rw = rw & ~flush;
    t.pc = pc & ~flush;
    sb_q.push_back(t);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sb_t e;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      RA1D = 4'($urandom); RA2D = 4'($urandom); WA3D = 4'($urandom);
      RegWriteD = 1'($urandom); MemtoRegD = 1'($urandom); PCSrcD = 1'($urandom);
      CondExE = 1'($urandom); FlushE = 1'($urandom); StallD = 1'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if ({RegWriteM, RegWriteW, MemtoRegE, PCSrcW} !== 4'b0000) begin
        errors++; $display("FAIL reset_ctl got %b exp 0000", {RegWriteM, RegWriteW, MemtoRegE, PCSrcW});
      end
      checks++;
      if (StallCnt !== 16'd0 || FlushCnt !== 16'd0) begin
        errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", StallCnt, FlushCnt);
      end
      checks++;
      if ({Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W} !== 4'b1111) begin
        errors++; $display("FAIL reset_match got %b exp 1111", {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W});
      end
      checks++;
      if (Match_12D_E !== ((RA1D == 4'd0) || (RA2D == 4'd0))) begin
        errors++; $display("FAIL reset_m12d got %b exp %b", Match_12D_E, ((RA1D == 4'd0) || (RA2D == 4'd0)));
      end
      checks++;
      if (PCWrPendingF !== PCSrcD) begin
        errors++; $display("FAIL reset_pcpend got %b exp %b", PCWrPendingF, PCSrcD);
      end
    end
    sb_q.delete();
    reset = 1'b1;
    issue(4'd0, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if (RegWriteW !== 1'b0) begin
      errors++; $display("FAIL lat_w1 got %b exp 0", RegWriteW);
    end
    issue(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if (RegWriteM !== 1'b1 || RegWriteW !== 1'b0) begin
      errors++; $display("FAIL lat_w2 got M=%b W=%b exp M=1 W=0", RegWriteM, RegWriteW);
    end
    issue(4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    if (sb_q.size() >= 3) begin
      e = sb_q.pop_front(); checks++;
      if ({RegWriteW, PCSrcW} !== {e.rw, e.pc}) begin
        errors++; $display("FAIL sb_w_reset got %b%b exp %b%b", RegWriteW, PCSrcW, e.rw, e.pc);
      end
    end
    checks++;
    if (Match_1E_W !== 1'b1 || Match_1E_M !== 1'b0) begin
      errors++; $display("FAIL lat_w3_match got W=%b M=%b exp W=1 M=0", Match_1E_W, Match_1E_M);
    end
  endtask

  task automatic test_forwarding();
    sb_t e;
    issue(4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    if (sb_q.size() >= 3) begin
      e = sb_q.pop_front(); checks++;
      if ({RegWriteW, PCSrcW} !== {e.rw, e.pc}) begin
        errors++; $display("FAIL sb_w_fwd0 got %b%b exp %b%b", RegWriteW, PCSrcW, e.rw, e.pc);
      end
    end
    issue(4'd3, 4'd9, 4'd10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (Match_12D_E !== 1'b1) begin
      errors++; $display("FAIL fwd_m12d got %b exp 1", Match_12D_E);
    end
    step();
    if (sb_q.size() >= 3) begin
      e = sb_q.pop_front(); checks++;
      if ({RegWriteW, PCSrcW} !== {e.rw, e.pc}) begin
        errors++; $display("FAIL sb_w_fwd1 got %b%b exp %b%b", RegWriteW, PCSrcW, e.rw, e.pc);
      end
    end
    checks++;
    if (Match_1E_M !== 1'b1 || Match_2E_M !== 1'b0) begin
      errors++; $display("FAIL fwd_1em got 1EM=%b 2EM=%b exp 1/0", Match_1E_M, Match_2E_M);
    end
    issue(4'd8, 4'd3, 4'd11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    if (sb_q.size() >= 3) begin
      e = sb_q.pop_front(); checks++;
      if ({RegWriteW, PCSrcW} !== {e.rw, e.pc}) begin
        errors++; $display("FAIL sb_w_fwd2 got %b%b exp %b%b", RegWriteW, PCSrcW, e.rw, e.pc);
      end
    end
    checks++;
    if (Match_2E_W !== 1'b1 || Match_1E_W !== 1'b0 || Match_2E_M !== 1'b0) begin
      errors++; $display("FAIL fwd_2ew got 2EW=%b 1EW=%b 2EM=%b exp 1/0/0", Match_2E_W, Match_1E_W, Match_2E_M);
    end
  endtask

  task automatic test_cond_fail();
    sb_t e;
    issue(4'd0, 4'd0, 4'd12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (PCWrPendingF !== 1'b1) begin
      errors++; $display("FAIL cf_pend_d got %b exp 1", PCWrPendingF);
    end
    step();
    if (sb_q.size() >= 3) begin
      e = sb_q.pop_front(); checks++;
      if ({RegWriteW, PCSrcW} !== {e.rw, e.pc}) begin
        errors++; $display("FAIL sb_w_cf0 got %b%b exp %b%b", RegWriteW, PCSrcW, e.rw, e.pc);
      end
    end
    issue(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (PCWrPendingF !== 1'b1) begin
      errors++; $display("FAIL cf_pend_e got %b exp 1", PCWrPendingF);
    end
    step();
    if (sb_q.size() >= 3) begin
      e = sb_q.pop_front(); checks++;
      if ({RegWriteW, PCSrcW} !== {e.rw, e.pc}) begin
        errors++; $display("FAIL sb_w_cf1 got %b%b exp %b%b", RegWriteW, PCSrcW, e.rw, e.pc);
      end
    end
    checks++;
    if (RegWriteM !== 1'b0 || PCWrPendingF !== 1'b0) begin
      errors++; $display("FAIL cf_m got rwM=%b pend=%b exp 0/0", RegWriteM, PCWrPendingF);
    end
    for (int i = 0; i < 2; i++) begin
      issue(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      if (sb_q.size() >= 3) begin
        e = sb_q.pop_front(); checks++;
        if ({RegWriteW, PCSrcW} !== {e.rw, e.pc}) begin
          errors++; $display("FAIL sb_w_cf2 got %b%b exp %b%b", RegWriteW, PCSrcW, e.rw, e.pc);
        end
      end
      checks++;
      if (PCSrcW !== 1'b0) begin
        errors++; $display("FAIL cf_pcsrcw got %b exp 0", PCSrcW);
      end
    end
  endtask

  task automatic test_load_use();
    sb_t e;
    issue(4'd0, 4'd0, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    if (sb_q.size() >= 3) begin
      e = sb_q.pop_front(); checks++;
      if ({RegWriteW, PCSrcW} !== {e.rw, e.pc}) begin
        errors++; $display("FAIL sb_w_lu0 got %b%b exp %b%b", RegWriteW, PCSrcW, e.rw, e.pc);
      end
    end
    issue(4'd7, 4'd2, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (Match_12D_E !== 1'b1 || MemtoRegE !== 1'b1) begin
      errors++; $display("FAIL lu_detect got m12d=%b mtrE=%b exp 1/1", Match_12D_E, MemtoRegE);
    end
    step();
    if (sb_q.size() >= 3) begin
      e = sb_q.pop_front(); checks++;
      if ({RegWriteW, PCSrcW} !== {e.rw, e.pc}) begin
        errors++; $display("FAIL sb_w_lu1 got %b%b exp %b%b", RegWriteW, PCSrcW, e.rw, e.pc);
      end
    end
    checks++;
    if (MemtoRegE !== 1'b0 || Match_1E_M !== 1'b0) begin
      errors++; $display("FAIL lu_bubble got mtrE=%b 1EM=%b exp 0/0", MemtoRegE, Match_1E_M);
    end
    checks++;
    if (StallCnt !== 16'd1 || FlushCnt !== 16'd1) begin
      errors++; $display("FAIL lu_cnt got %0d/%0d exp 1/1", StallCnt, FlushCnt);
    end
    issue(4'd7, 4'd2, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (Match_12D_E !== 1'b0) begin
      errors++; $display("FAIL lu_wa3e_zero got %b exp 0", Match_12D_E);
    end
    step();
    if (sb_q.size() >= 3) begin
      e = sb_q.pop_front(); checks++;
      if ({RegWriteW, PCSrcW} !== {e.rw, e.pc}) begin
        errors++; $display("FAIL sb_w_lu2 got %b%b exp %b%b", RegWriteW, PCSrcW, e.rw, e.pc);
      end
    end
    checks++;
    if (Match_1E_W !== 1'b1 || StallCnt !== 16'd1 || FlushCnt !== 16'd1) begin
      errors++; $display("FAIL lu_replay got 1EW=%b cnt=%0d/%0d exp 1 1/1", Match_1E_W, StallCnt, FlushCnt);
    end
    issue(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    if (sb_q.size() >= 3) begin
      e = sb_q.pop_front(); checks++;
      if ({RegWriteW, PCSrcW} !== {e.rw, e.pc}) begin
        errors++; $display("FAIL sb_w_lu3 got %b%b exp %b%b", RegWriteW, PCSrcW, e.rw, e.pc);
      end
    end
    checks++;
    if (RegWriteM !== 1'b1) begin
      errors++; $display("FAIL lu_use_m got %b exp 1", RegWriteM);
    end
  endtask

  task automatic test_branch();
    sb_t e;
    for (int i = 0; i < 5; i++) begin
      issue(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, (i == 0), 1'b1, 1'b0, 1'b0);
      checks++;
      if (PCWrPendingF !== (i < 3)) begin
        errors++; $display("FAIL br_pend[%0d] got %b exp %b", i, PCWrPendingF, (i < 3));
      end
      step();
      if (sb_q.size() >= 3) begin
        e = sb_q.pop_front(); checks++;
        if ({RegWriteW, PCSrcW} !== {e.rw, e.pc}) begin
          errors++; $display("FAIL sb_w_br[%0d] got %b%b exp %b%b", i, RegWriteW, PCSrcW, e.rw, e.pc);
        end
      end
      if (i >= 2) begin
        checks++;
        if (PCSrcW !== (i == 2)) begin
          errors++; $display("FAIL br_pcsrcw[%0d] got %b exp %b", i, PCSrcW, (i == 2));
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    sb_t e;
    issue(4'd0, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    if (sb_q.size() >= 3) begin
      e = sb_q.pop_front(); checks++;
      if ({RegWriteW, PCSrcW} !== {e.rw, e.pc}) begin
        errors++; $display("FAIL sb_w_mr0 got %b%b exp %b%b", RegWriteW, PCSrcW, e.rw, e.pc);
      end
    end
    issue(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if (RegWriteM !== 1'b1 || StallCnt !== 16'd2) begin
      errors++; $display("FAIL mr_pre got rwM=%b stall=%0d exp 1/2", RegWriteM, StallCnt);
    end
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (RegWriteM !== 1'b0 || StallCnt !== 16'd0 || FlushCnt !== 16'd0 || Match_1E_M !== 1'b1) begin
      errors++; $display("FAIL mr_async got rwM=%b cnt=%0d/%0d 1EM=%b exp 0 0/0 1",
                         RegWriteM, StallCnt, FlushCnt, Match_1E_M);
    end
    step();
    sb_q.delete();
    reset = 1'b1;
  endtask

  task automatic test_saturation();
    sb_t e;
    int  exp_s;
    for (int k = 1; k <= 6; k++) begin
      issue(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      cnt_q.push_back((k < 3) ? k : 3);
      step();
      if (sb_q.size() >= 3) begin
        e = sb_q.pop_front(); checks++;
        if ({RegWriteW, PCSrcW} !== {e.rw, e.pc}) begin
          errors++; $display("FAIL sb_w_sat[%0d] got %b%b exp %b%b", k, RegWriteW, PCSrcW, e.rw, e.pc);
        end
      end
      exp_s = cnt_q.pop_front();
      checks++;
      if (s_StallCnt !== 2'(exp_s) || s_FlushCnt !== 2'd0) begin
        errors++; $display("FAIL sat_cnt[%0d] got %0d/%0d exp %0d/0", k, s_StallCnt, s_FlushCnt, exp_s);
      end
      checks++;
      if (StallCnt !== 16'(k)) begin
        errors++; $display("FAIL wide_cnt[%0d] got %0d exp %0d", k, StallCnt, k);
      end
    end
    issue(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    reset = 1'b0;
    RA1D = 4'd0; RA2D = 4'd0; WA3D = 4'd0;
    RegWriteD = 1'b0; MemtoRegD = 1'b0; PCSrcD = 1'b0;
    CondExE = 1'b0; FlushE = 1'b0; StallD = 1'b0;
    test_reset();
    test_forwarding();
    test_cond_fail();
    test_load_use();
    test_branch();
    test_mid_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
